// File: rtl/klp32_pkg.sv
// Shared constants and types for the KLP32 memory stage.
package klp32_pkg;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane handling: store replication and byte enables,
// load extraction with sign/zero extension, and alignment/mode checks.
module load_store_align
  import klp32_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  mode,
  input  logic [31:0] store_data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misaligned,
  output logic        illegal_mode,
  input  logic [1:0]  load_offset,
  input  logic [2:0]  load_mode,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [31:0] lane;

  // Access size comes from funct3[1:0]; the unsigned variants share B/H sizing.
  always_comb begin
    wdata        = store_data;
    be           = 4'b1111;
    misaligned   = 1'b0;
    illegal_mode = !(mode inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    case (mode[1:0])
      2'b00: begin
        wdata = {4{store_data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      2'b01: begin
        wdata      = {2{store_data[15:0]}};
        be         = 4'b0011 << addr_lo;
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

  always_comb begin
    lane = rdata >> {load_offset, 3'b000};
    case (load_mode)
      F3_B:    load_data = {{24{lane[7]}}, lane[7:0]};
      F3_H:    load_data = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   load_data = {24'h0, lane[7:0]};
      F3_HU:   load_data = {16'h0, lane[15:0]};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// KLP32 MEM stage: issues aligned loads/stores over a req/ack port, stalls
// execute while an access is outstanding, and registers write-back results.
module memory_stage
  import klp32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_store_data,
  input  logic        i_mem_rw,
  input  logic [2:0]  i_load_store_mode,
  input  logic [1:0]  i_wb_sel,
  input  logic [31:0] i_pc_inc,
  input  logic        i_reg_wr_en,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_memory_valid,
  output logic        o_memory_fault,
  output logic [31:0] o_memory_inst,
  output logic [31:0] o_memory_alu_result,
  output logic [31:0] o_memory_load_data,
  output logic [31:0] o_memory_pc_inc,
  output logic [1:0]  o_memory_wb_sel,
  output logic        o_memory_reg_wr_en
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_t       state, next_state;
  logic [CNT_W-1:0] timeout_cnt;
  logic             mem_op, accept, op_fault, start_access, timeout_hit;
  logic [31:0]      store_wdata, load_data;
  logic [3:0]       store_be;
  logic             misaligned, illegal_mode;
  logic [31:0]      addr_q, wdata_q;
  logic [3:0]       be_q;
  logic             we_q, reg_wr_en_q;
  logic [2:0]       mode_q;
  logic [1:0]       offset_q;

  assign mem_op       = i_mem_rw | (i_wb_sel == WB_MEM);
  assign accept       = i_valid && (state == IDLE);
  assign op_fault     = mem_op && (misaligned || illegal_mode);
  assign start_access = accept && mem_op && !op_fault;
  assign timeout_hit  = (state == BUSY) && !i_dmem_ack &&
                        (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  load_store_align u_align (
    .addr_lo      (i_alu_result[1:0]),
    .mode         (i_load_store_mode),
    .store_data   (i_store_data),
    .wdata        (store_wdata),
    .be           (store_be),
    .misaligned   (misaligned),
    .illegal_mode (illegal_mode),
    .load_offset  (offset_q),
    .load_mode    (mode_q),
    .rdata        (i_dmem_rdata),
    .load_data    (load_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_access) next_state = BUSY;
      BUSY:    if (i_dmem_ack || timeout_hit) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Sideband goes straight to the result registers on accept; valid only
  // rises once the access completes, so they are hidden while BUSY.
  always_ff @(posedge clk) begin
    if (!reset) begin
      timeout_cnt         <= '0;
      addr_q              <= '0;
      wdata_q             <= '0;
      be_q                <= '0;
      we_q                <= 1'b0;
      mode_q              <= '0;
      offset_q            <= '0;
      reg_wr_en_q         <= 1'b0;
      o_memory_valid      <= 1'b0;
      o_memory_fault      <= 1'b0;
      o_memory_inst       <= '0;
      o_memory_alu_result <= '0;
      o_memory_load_data  <= '0;
      o_memory_pc_inc     <= '0;
      o_memory_wb_sel     <= '0;
      o_memory_reg_wr_en  <= 1'b0;
    end else begin
      o_memory_valid <= 1'b0;
      if (accept) begin
        o_memory_inst       <= i_inst;
        o_memory_alu_result <= i_alu_result;
        o_memory_pc_inc     <= i_pc_inc;
        o_memory_wb_sel     <= i_wb_sel;
        if (start_access) begin
          timeout_cnt <= '0;
          addr_q      <= {i_alu_result[31:2], 2'b00};
          wdata_q     <= store_wdata;
          be_q        <= i_mem_rw ? store_be : 4'b1111;
          we_q        <= i_mem_rw;
          mode_q      <= i_load_store_mode;
          offset_q    <= i_alu_result[1:0];
          reg_wr_en_q <= i_reg_wr_en;
        end else begin
          o_memory_valid     <= 1'b1;
          o_memory_fault     <= op_fault;
          o_memory_load_data <= '0;
          o_memory_reg_wr_en <= i_reg_wr_en && !op_fault;
        end
      end else if (state == BUSY) begin
        if (i_dmem_ack) begin
          o_memory_valid     <= 1'b1;
          o_memory_fault     <= 1'b0;
          o_memory_load_data <= we_q ? 32'h0 : load_data;
          o_memory_reg_wr_en <= reg_wr_en_q;
        end else if (timeout_hit) begin
          o_memory_valid     <= 1'b1;
          o_memory_fault     <= 1'b1;
          o_memory_load_data <= '0;
          o_memory_reg_wr_en <= 1'b0;
        end else begin
          timeout_cnt <= timeout_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_stall      = (state == BUSY);
  assign o_dmem_req   = (state == BUSY);
  assign o_dmem_we    = (state == BUSY) && we_q;
  assign o_dmem_be    = (state == BUSY) ? be_q : 4'b0000;
  assign o_dmem_addr  = addr_q;
  assign o_dmem_wdata = wdata_q;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized self-checking bench for memory_stage with a byte-level memory model.
module tb_memory_stage;
  import klp32_pkg::*;

  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [31:0] pc;
    logic        rw;
    logic [2:0]  mode;
    logic [1:0]  wb;
    logic        wr;
  } ins_t;

  typedef struct packed {
    logic        fault;
    logic [31:0] inst;
    logic [31:0] alu;
    logic [31:0] load;
    logic [31:0] pc;
    logic [1:0]  wb;
    logic        wr;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid, i_mem_rw, i_reg_wr_en, i_dmem_ack;
  logic [31:0] i_inst, i_alu_result, i_store_data, i_pc_inc, i_dmem_rdata;
  logic [2:0]  i_load_store_mode;
  logic [1:0]  i_wb_sel;
  logic        o_stall, o_dmem_req, o_dmem_we, o_memory_valid, o_memory_fault;
  logic        o_memory_reg_wr_en;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_memory_inst, o_memory_alu_result;
  logic [31:0] o_memory_load_data, o_memory_pc_inc;
  logic [3:0]  o_dmem_be;
  logic [1:0]  o_memory_wb_sel;

  int          checks = 0;
  int          errors = 0;
  logic        checking = 1'b0;
  logic        exp_busy = 1'b0;
  logic        exp_valid = 1'b0;
  res_t        exp_res;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  logic        exp_we;
  logic [31:0] mem [0:15];
  int          busy_seen;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_be;
  logic        seen_we;

  always #5 clk = ~clk;

  memory_stage #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_inst(i_inst),
    .i_alu_result(i_alu_result), .i_store_data(i_store_data), .i_mem_rw(i_mem_rw),
    .i_load_store_mode(i_load_store_mode), .i_wb_sel(i_wb_sel), .i_pc_inc(i_pc_inc),
    .i_reg_wr_en(i_reg_wr_en), .o_stall(o_stall), .o_dmem_req(o_dmem_req),
    .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
    .o_dmem_be(o_dmem_be), .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
    .o_memory_valid(o_memory_valid), .o_memory_fault(o_memory_fault),
    .o_memory_inst(o_memory_inst), .o_memory_alu_result(o_memory_alu_result),
    .o_memory_load_data(o_memory_load_data), .o_memory_pc_inc(o_memory_pc_inc),
    .o_memory_wb_sel(o_memory_wb_sel), .o_memory_reg_wr_en(o_memory_reg_wr_en)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] mode);
    if (mode == 3'd0 || mode == 3'd4) return 1;
    if (mode == 3'd1 || mode == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit isMemOp(input ins_t t);
    return t.rw || (t.wb == 2'b00);
  endfunction

  function automatic bit opFaults(input ins_t t);
    bit legal;
    legal = t.mode inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    return isMemOp(t) && (!legal || (int'(t.alu[1:0]) % nbytes(t.mode)) != 0);
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] mode, input logic [31:0] addr,
                                            input logic [31:0] rdata);
    logic [31:0]        lane;
    logic signed [31:0] s;
    lane = rdata >> (8 * int'(addr[1:0]));
    case (mode)
      3'd0:    begin s = $signed(lane[7:0]);  return s; end
      3'd1:    begin s = $signed(lane[15:0]); return s; end
      3'd4:    return lane & 32'h0000_00FF;
      3'd5:    return lane & 32'h0000_FFFF;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] modelBe(input ins_t t);
    logic [3:0] be;
    int off, n;
    off = int'(t.alu[1:0]);
    n = nbytes(t.mode);
    if (!t.rw) return 4'hF;
    for (int k = 0; k < 4; k++) be[k] = (k >= off) && (k < off + n);
    return be;
  endfunction

  function automatic logic [31:0] modelWdata(input ins_t t);
    logic [31:0] w;
    int n;
    n = nbytes(t.mode);
    for (int k = 0; k < 4; k++) w[8*k +: 8] = t.sd[8*(k % n) +: 8];
    return w;
  endfunction

  function automatic res_t mkRes(input ins_t t, input logic fault, input logic [31:0] load,
                                 input logic wr);
    res_t r;
    r.fault = fault; r.inst = t.inst; r.alu = t.alu; r.load = load;
    r.pc = t.pc; r.wb = t.wb; r.wr = wr;
    return r;
  endfunction

  function automatic ins_t mkIns(input logic [31:0] alu, input logic [31:0] sd, input logic rw,
                                 input logic [2:0] mode, input logic [1:0] wb, input logic wr);
    ins_t t;
    t.inst = $urandom; t.pc = $urandom; t.alu = alu; t.sd = sd;
    t.rw = rw; t.mode = mode; t.wb = wb; t.wr = wr;
    return t;
  endfunction

  task automatic idleCycle(input logic ack);
    i_valid = 1'b0;
    i_dmem_ack = ack;
    i_dmem_rdata = $urandom;
    @(posedge clk); #1;
    i_dmem_ack = 1'b0;
    exp_valid = 1'b0;
    exp_busy = 1'b0;
  endtask

  // Present one instruction, respond on the data port after wait_cycles
  // (TIMEOUT or more means never), and leave the bench in the result cycle.
  task automatic applyStimulus(input ins_t t, input int wait_cycles, input bit use_rd,
                               input logic [31:0] rd);
    bit          faulty, timed_out, acked;
    logic [31:0] rdata, wd;
    logic [3:0]  be;
    int          c, idx;
    faulty = opFaults(t);
    i_valid = 1'b1; i_inst = t.inst; i_alu_result = t.alu; i_store_data = t.sd;
    i_pc_inc = t.pc; i_mem_rw = t.rw; i_load_store_mode = t.mode; i_wb_sel = t.wb;
    i_reg_wr_en = t.wr;
    busy_seen = 0;
    @(posedge clk); #1;
    i_valid = 1'b0;
    if (!isMemOp(t) || faulty) begin
      exp_busy = 1'b0;
      exp_valid = 1'b1;
      exp_res = mkRes(t, faulty, 32'h0, faulty ? 1'b0 : t.wr);
      return;
    end
    be = modelBe(t);
    wd = modelWdata(t);
    exp_valid = 1'b0; exp_busy = 1'b1;
    exp_addr = {t.alu[31:2], 2'b00}; exp_we = t.rw; exp_be = be; exp_wdata = wd;
    seen_addr = o_dmem_addr; seen_wdata = o_dmem_wdata; seen_be = o_dmem_be; seen_we = o_dmem_we;
    idx = int'(t.alu[5:2]);
    rdata = use_rd ? rd : mem[idx];
    timed_out = (wait_cycles >= TIMEOUT);
    acked = 1'b0;
    c = 0;
    while (!acked && !(timed_out && c == TIMEOUT)) begin
      if (o_stall) busy_seen++;
      if (!timed_out && c == wait_cycles) begin
        i_dmem_ack = 1'b1;
        i_dmem_rdata = rdata;
      end else begin
        i_dmem_ack = 1'b0;
        i_dmem_rdata = $urandom;
        i_valid = 1'($urandom_range(0, 1));
        i_inst = $urandom; i_alu_result = $urandom; i_wb_sel = 2'($urandom_range(0, 2));
      end
      @(posedge clk); #1;
      acked = i_dmem_ack;
      c++;
    end
    i_dmem_ack = 1'b0;
    i_valid = 1'b0;
    exp_busy = 1'b0;
    exp_valid = 1'b1;
    if (acked) begin
      if (t.rw) for (int k = 0; k < 4; k++) if (be[k]) mem[idx][8*k +: 8] = wd[8*k +: 8];
      exp_res = mkRes(t, 1'b0, t.rw ? 32'h0 : modelLoad(t.mode, t.alu, rdata), t.wr);
    end else begin
      exp_res = mkRes(t, 1'b1, 32'h0, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("stall", o_stall, exp_busy);
      checkOutput("dmem_req", o_dmem_req, exp_busy);
      if (exp_busy) begin
        checkOutput("dmem_addr", o_dmem_addr, exp_addr);
        checkOutput("dmem_we", o_dmem_we, exp_we);
        checkOutput("dmem_be", o_dmem_be, exp_be);
        if (exp_we) checkOutput("dmem_wdata", o_dmem_wdata, exp_wdata);
      end
      checkOutput("valid", o_memory_valid, exp_valid);
      if (exp_valid) begin
        checkOutput("fault", o_memory_fault, exp_res.fault);
        checkOutput("inst", o_memory_inst, exp_res.inst);
        checkOutput("alu_result", o_memory_alu_result, exp_res.alu);
        checkOutput("load_data", o_memory_load_data, exp_res.load);
        checkOutput("pc_inc", o_memory_pc_inc, exp_res.pc);
        checkOutput("wb_sel", o_memory_wb_sel, exp_res.wb);
        checkOutput("reg_wr_en", o_memory_reg_wr_en, exp_res.wr);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ins_t t;
    int   r, w;
    logic [2:0] m;
    reset = 1'b0; i_valid = 1'b0; i_inst = '0; i_alu_result = '0; i_store_data = '0;
    i_mem_rw = 1'b0; i_load_store_mode = '0; i_wb_sel = '0; i_pc_inc = '0;
    i_reg_wr_en = 1'b0; i_dmem_ack = 1'b0; i_dmem_rdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_stall", o_stall, 1'b0);
    checkOutput("rst_req", o_dmem_req, 1'b0);
    checkOutput("rst_we", o_dmem_we, 1'b0);
    checkOutput("rst_be", o_dmem_be, 4'h0);
    checkOutput("rst_valid", o_memory_valid, 1'b0);
    checkOutput("rst_fault", o_memory_fault, 1'b0);
    checkOutput("rst_alu", o_memory_alu_result, 32'h0);
    checkOutput("rst_load", o_memory_load_data, 32'h0);
    checkOutput("rst_wr", o_memory_reg_wr_en, 1'b0);
    reset = 1'b1;
    checking = 1'b1;
    idleCycle(1'b0);

    t = mkIns(32'h0000_0037, 32'h0, 1'b0, 3'd0, WB_ALU, 1'b1);
    applyStimulus(t, 0, 1'b0, 32'h0);
    checkOutput("add_valid", o_memory_valid, 1'b1);
    checkOutput("add_alu", o_memory_alu_result, 32'h0000_0037);
    checkOutput("add_req", o_dmem_req, 1'b0);
    idleCycle(1'b0);

    t = mkIns(32'h0000_1003, 32'h0, 1'b0, F3_B, WB_MEM, 1'b1);
    applyStimulus(t, 3, 1'b1, 32'h80AA_BBCC);
    checkOutput("lb_stall_cycles", busy_seen, 32'd4);
    checkOutput("lb_data", o_memory_load_data, 32'hFFFF_FF80);

    t = mkIns(32'h0000_1002, 32'h0, 1'b0, F3_HU, WB_MEM, 1'b1);
    applyStimulus(t, 1, 1'b1, 32'h8001_1234);
    checkOutput("lhu_data", o_memory_load_data, 32'h0000_8001);
    t = mkIns(32'h0000_1000, 32'h0, 1'b0, F3_W, WB_MEM, 1'b1);
    applyStimulus(t, 0, 1'b1, 32'h8001_1234);
    checkOutput("lw_data", o_memory_load_data, 32'h8001_1234);

    t = mkIns(32'h0000_2001, 32'h1234_56AB, 1'b1, F3_B, WB_ALU, 1'b0);
    applyStimulus(t, 2, 1'b0, 32'h0);
    checkOutput("sb_addr", seen_addr, 32'h0000_2000);
    checkOutput("sb_wdata", seen_wdata, 32'hABAB_ABAB);
    checkOutput("sb_be", seen_be, 4'b0010);
    checkOutput("sb_we", seen_we, 1'b1);

    t = mkIns(32'h0000_1002, 32'h0, 1'b0, F3_W, WB_MEM, 1'b1);
    applyStimulus(t, 0, 1'b0, 32'h0);
    checkOutput("mis_fault", o_memory_fault, 1'b1);
    checkOutput("mis_wr", o_memory_reg_wr_en, 1'b0);
    checkOutput("mis_req", o_dmem_req, 1'b0);

    t = mkIns(32'h0000_1004, 32'h0, 1'b0, F3_W, WB_MEM, 1'b1);
    applyStimulus(t, TIMEOUT, 1'b0, 32'h0);
    checkOutput("to_cycles", busy_seen, TIMEOUT);
    checkOutput("to_fault", o_memory_fault, 1'b1);
    checkOutput("to_wr", o_memory_reg_wr_en, 1'b0);
    idleCycle(1'b0);

    // Reset pulled low in the middle of an outstanding load.
    i_valid = 1'b1; i_alu_result = 32'h0000_1008; i_mem_rw = 1'b0;
    i_load_store_mode = F3_W; i_wb_sel = WB_MEM; i_reg_wr_en = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    exp_busy = 1'b1; exp_addr = 32'h0000_1008; exp_we = 1'b0; exp_be = 4'hF;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    exp_busy = 1'b0; exp_valid = 1'b0;
    checkOutput("rstbusy_req", o_dmem_req, 1'b0);
    checkOutput("rstbusy_stall", o_stall, 1'b0);
    reset = 1'b1;
    idleCycle(1'b1);
    checkOutput("stray_ack_valid", o_memory_valid, 1'b0);
    checkOutput("stray_ack_stall", o_stall, 1'b0);
    idleCycle(1'b0);

    repeat (300) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        idleCycle(1'($urandom_range(0, 1)));
      end else begin
        if ($urandom_range(0, 9) < 8) begin
          case ($urandom_range(0, 4))
            0: m = 3'd0;
            1: m = 3'd1;
            2: m = 3'd2;
            3: m = 3'd4;
            default: m = 3'd5;
          endcase
        end else begin
          m = 3'($urandom_range(0, 7));
        end
        t = mkIns(32'h0000_1000 + 32'($urandom_range(0, 63)), $urandom,
                  1'($urandom_range(0, 1)), m, 2'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)));
        w = ($urandom_range(0, 19) == 0) ? TIMEOUT : $urandom_range(0, 4);
        applyStimulus(t, w, 1'b0, 32'h0);
      end
    end
    idleCycle(1'b0);
    idleCycle(1'b0);
    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
